// File: rtl/inert_spi_serf.sv
// SPI responder model of the inertial sensor: 16-bit frames, config registers, sample snapshots, INT.
// Optional STATUS register at 0x1E (INT + overrun) is enabled by defining INERT_SERF_STATUS_EN.
module inert_spi_serf #(
  parameter logic [7:0]  WHOAMI_VAL = 8'h6A,
  parameter int unsigned SYNC_STG   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] roll_rt,
  input  logic [15:0] yaw_rt,
  input  logic [15:0] AY,
  input  logic [15:0] AZ
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic [SYNC_STG-1:0] sclk_sync, ss_sync, mosi_sync;
  logic        sclk_prev, ss_prev;
  logic        sclk_s, ss_s, mosi_s;
  logic        sclk_rise, ss_rise, ss_fall;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        full_q, full_d;
  logic [15:0] shft_q, shft_d;
  logic        frame_done, end_frame, transfer;
  logic        wr_en, rd_done;
  logic [6:0]  fr_addr;
  logic [7:0]  cmd_byte, rdata;

  logic [7:0]  int_ctrl_q, ctrl1_q, ctrl2_q, ctrl5_q;
  logic [15:0] roll_q, yaw_q, ay_q, az_q;
  logic [15:0] roll_h, yaw_h, ay_h, az_h;
  logic        pend_q, int_q, int_d;
  logic        ovr_q;

  // SCLK and SS_n idle high, so their synchronizers reset high to avoid a false edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '1;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b1;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STG-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STG-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], MOSI};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STG-1];
  assign ss_s      = ss_sync[SYNC_STG-1];
  assign mosi_s    = mosi_sync[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ss_rise   = ss_s & ~ss_prev;
  assign ss_fall   = ~ss_s & ss_prev;

  assign cmd_byte  = {shft_q[6:0], mosi_s};
  assign fr_addr   = shft_q[14:8];

  always_comb begin
    rdata = '0;
    if (cmd_byte[7]) begin
      case (cmd_byte[6:0])
        7'h0D: rdata = int_ctrl_q;
        7'h0F: rdata = WHOAMI_VAL;
        7'h10: rdata = ctrl1_q;
        7'h11: rdata = ctrl2_q;
        7'h14: rdata = ctrl5_q;
`ifdef INERT_SERF_STATUS_EN
        7'h1E: rdata = {6'b0, ovr_q, int_q};
`endif
        7'h24: rdata = roll_q[7:0];
        7'h25: rdata = roll_q[15:8];
        7'h26: rdata = yaw_q[7:0];
        7'h27: rdata = yaw_q[15:8];
        7'h2A: rdata = ay_q[7:0];
        7'h2B: rdata = ay_q[15:8];
        7'h2C: rdata = az_q[7:0];
        7'h2D: rdata = az_q[15:8];
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    shft_d     = shft_q;
    frame_done = 1'b0;
    end_frame  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          full_d  = 1'b0;
        end
      end
      default: begin
        if (ss_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          full_d  = 1'b0;
        end else if (ss_rise) begin
          state_d    = IDLE;
          end_frame  = 1'b1;
          frame_done = (state_q == DATA) && full_q;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + 4'd1;
          if (state_q == CMD && cnt_q == 4'd7) begin
            // read data is loaded above the command byte so it leaves MISO next
            shft_d  = {rdata, cmd_byte};
            state_d = DATA;
          end else begin
            shft_d = {shft_q[14:0], mosi_s};
          end
          if (state_q == DATA) full_d = (cnt_q == 4'd15);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      shft_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      shft_q  <= shft_d;
    end
  end

  assign wr_en    = frame_done & ~shft_q[15];
  assign rd_done  = frame_done & shft_q[15];
  assign transfer = pend_q & ((state_q == IDLE) | end_frame);

  // a transfer in the same cycle as a clearing event wins
  always_comb begin
    int_d = int_q;
    if (rd_done && fr_addr == 7'h2D) int_d = 1'b0;
    if (wr_en && fr_addr == 7'h0D && !shft_q[1]) int_d = 1'b0;
    if (transfer && int_ctrl_q[1]) int_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_ctrl_q <= '0;
      ctrl1_q    <= '0;
      ctrl2_q    <= '0;
      ctrl5_q    <= '0;
      roll_q     <= '0;
      yaw_q      <= '0;
      ay_q       <= '0;
      az_q       <= '0;
      roll_h     <= '0;
      yaw_h      <= '0;
      ay_h       <= '0;
      az_h       <= '0;
      pend_q     <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (fr_addr)
          7'h0D: int_ctrl_q <= shft_q[7:0];
          7'h10: ctrl1_q    <= shft_q[7:0];
          7'h11: ctrl2_q    <= shft_q[7:0];
          7'h14: ctrl5_q    <= shft_q[7:0];
          default: ;
        endcase
      end
      if (smpl_vld) begin
        roll_h <= roll_rt;
        yaw_h  <= yaw_rt;
        ay_h   <= AY;
        az_h   <= AZ;
      end
      if (transfer) begin
        roll_q <= roll_h;
        yaw_q  <= yaw_h;
        ay_q   <= ay_h;
        az_q   <= az_h;
      end
      pend_q <= smpl_vld | (pend_q & ~transfer);
      int_q  <= int_d;
    end
  end

`ifdef INERT_SERF_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (transfer && int_q) begin
      ovr_q <= 1'b1;
    end else if (rd_done && fr_addr == 7'h1E) begin
      ovr_q <= 1'b0;
    end
  end
`else
  assign ovr_q = 1'b0;
`endif

  assign MISO = shft_q[15];
  assign INT  = int_q;

endmodule

// File: tb/tb_inert_spi_serf.sv
// Self-checking bench for inert_spi_serf: drives SPI frames as a master, scoreboards read responses.
module tb_inert_spi_serf;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO, INT;
  logic        smpl_vld = 1'b0;
  logic [15:0] roll_rt = '0, yaw_rt = '0, AY = '0, AZ = '0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [15:0] rx;

  inert_spi_serf #(.WHOAMI_VAL(8'h6A), .SYNC_STG(2)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .smpl_vld(smpl_vld),
    .roll_rt(roll_rt), .yaw_rt(yaw_rt), .AY(AY), .AZ(AZ)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_smpl();
    @(posedge clk); #1 smpl_vld = 1'b1;
    @(posedge clk); #1 smpl_vld = 1'b0;
  endtask

  // nrise < 16 aborts the frame; pulse_bit >= 0 strobes smpl_vld during that bit
  task automatic spi_frame(input logic [15:0] tx, input int nrise, input int pulse_bit,
                           input logic chk, input logic [7:0] exp, input string name);
    logic [7:0] want;
    if (chk) exp_q.push_back(exp);
    rx = '0;
    wait_clk(1);
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = tx[15-i];
      if (i == pulse_bit) begin
        pulse_smpl();
        wait_clk(HALF - 2);
      end else begin
        wait_clk(HALF);
      end
      rx = {rx[14:0], MISO};
      SCLK = 1'b1;
      wait_clk(HALF);
    end
    SS_n = 1'b1;
    wait_clk(HALF);
    if (chk) begin
      want = exp_q.pop_front();
      checks++;
      if (rx[7:0] !== want) begin
        errors++;
        $display("FAIL %s: got %02h expected %02h", name, rx[7:0], want);
      end
    end
  endtask

  task automatic check_int(input logic exp, input string name);
    checks++;
    if (INT !== exp) begin
      errors++;
      $display("FAIL %s: INT got %b expected %b", name, INT, exp);
    end
  endtask

  task automatic test_reset();
    wait_clk(3);
    checks++;
    if (MISO !== 1'b0) begin
      errors++;
      $display("FAIL reset_miso: got %b expected 0", MISO);
    end
    check_int(1'b0, "reset_int");
    rst = 1'b0;
    wait_clk(4);
    spi_frame(16'h8F00, 16, -1, 1'b1, 8'h6A, "whoami");
    check_int(1'b0, "whoami_int");
  endtask

  task automatic test_config();
    spi_frame(16'h0D02, 16, -1, 1'b0, 8'h00, "");
    spi_frame(16'h1053, 16, -1, 1'b0, 8'h00, "");
    spi_frame(16'h1150, 16, -1, 1'b0, 8'h00, "");
    spi_frame(16'h1460, 16, -1, 1'b0, 8'h00, "");
    spi_frame(16'h0F55, 16, -1, 1'b0, 8'h00, "");
    spi_frame(16'h2411, 16, -1, 1'b0, 8'h00, "");
    spi_frame(16'h9000, 16, -1, 1'b1, 8'h53, "ctrl1");
    spi_frame(16'h8D00, 16, -1, 1'b1, 8'h02, "int_ctrl");
    spi_frame(16'h9100, 16, -1, 1'b1, 8'h50, "ctrl2");
    spi_frame(16'h9400, 16, -1, 1'b1, 8'h60, "ctrl5");
    spi_frame(16'h8F00, 16, -1, 1'b1, 8'h6A, "whoami_ro");
    spi_frame(16'hA400, 16, -1, 1'b1, 8'h00, "roll_ro");
    spi_frame(16'h9200, 16, -1, 1'b1, 8'h00, "unmapped");
    check_int(1'b0, "config_int");
  endtask

  task automatic test_sample();
    roll_rt = 16'h1234; yaw_rt = 16'h5678; AY = 16'h9ABC; AZ = 16'hFEDC;
    pulse_smpl();
    wait_clk(4);
    check_int(1'b1, "sample_int_set");
    spi_frame(16'hA400, 16, -1, 1'b1, 8'h34, "roll_l");
    spi_frame(16'hA500, 16, -1, 1'b1, 8'h12, "roll_h");
    check_int(1'b1, "int_held");
    spi_frame(16'hA700, 16, -1, 1'b1, 8'h56, "yaw_h");
    spi_frame(16'hAA00, 16, -1, 1'b1, 8'hBC, "ay_l");
    spi_frame(16'hAC00, 16, -1, 1'b1, 8'hDC, "az_l");
    check_int(1'b1, "int_held_az_l");
    spi_frame(16'hAD00, 16, -1, 1'b1, 8'hFE, "az_h");
    check_int(1'b0, "int_clr_az_h");
  endtask

  task automatic test_midframe();
    roll_rt = 16'hABCD;
    spi_frame(16'hA400, 16, 4, 1'b1, 8'h34, "mid_old");
    check_int(1'b1, "mid_int_after");
    spi_frame(16'hA400, 16, -1, 1'b1, 8'hCD, "mid_new_l");
    spi_frame(16'hA500, 16, -1, 1'b1, 8'hAB, "mid_new_h");
    spi_frame(16'hAD00, 16, -1, 1'b1, 8'hFE, "mid_az_h");
    check_int(1'b0, "mid_int_clr");
  endtask

  task automatic test_abort();
    spi_frame(16'h1011, 10, -1, 1'b0, 8'h00, "");
    spi_frame(16'h9100, 16, -1, 1'b1, 8'h50, "abort_ctrl2");
    spi_frame(16'h1144, 16, -1, 1'b0, 8'h00, "");
    spi_frame(16'h9100, 16, -1, 1'b1, 8'h44, "after_abort");
    // abort a 0x2D read: INT must not clear
    pulse_smpl();
    wait_clk(4);
    spi_frame(16'hAD00, 12, -1, 1'b0, 8'h00, "");
    check_int(1'b1, "abort_no_clr");
  endtask

  task automatic test_int_disable();
    spi_frame(16'h0D00, 16, -1, 1'b0, 8'h00, "");
    check_int(1'b0, "disable_clr");
    roll_rt = 16'h0F0E;
    pulse_smpl();
    wait_clk(4);
    check_int(1'b0, "disabled_no_set");
    spi_frame(16'hA400, 16, -1, 1'b1, 8'h0E, "disabled_data");
    spi_frame(16'h0D02, 16, -1, 1'b0, 8'h00, "");
  endtask

  task automatic test_status();
    pulse_smpl();
    wait_clk(4);
    pulse_smpl();
    wait_clk(4);
`ifdef INERT_SERF_STATUS_EN
    spi_frame(16'h9E00, 16, -1, 1'b1, 8'h03, "status_ovr");
    spi_frame(16'h9E00, 16, -1, 1'b1, 8'h01, "status_clr");
`else
    spi_frame(16'h9E00, 16, -1, 1'b1, 8'h00, "status_unmapped");
`endif
    check_int(1'b1, "status_int");
  endtask

  initial begin
    test_reset();
    test_config();
    test_sample();
    test_midframe();
    test_abort();
    test_int_disable();
    test_status();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/inert_spi_serf.md
Name: inert_spi_serf

Overview:
- SPI serf (responder) model of the inertial sensor; it is the opposite end of the SPI link driven by the inertial interface master.
- Decodes 16-bit frames: bit15 = read (1) / write (0), bits[14:8] = register address, bits[7:0] = write data.
- Holds the config register file plus snapshot data registers for roll rate, yaw rate, AY and AZ, loaded from parallel sample inputs.
- Drives INT to signal new data. Used in the full-chip testbench and in FPGA self-test.

Parameters:
WHOAMI_VAL  8'h6A  read-only value returned at address 0x0F
SYNC_STG    2      synchronizer depth on SCLK/SS_n/MOSI (min 2)

Ports:
clk       in   1   system clock
rst       in   1   asynchronous, active-high reset
SS_n      in   1   serf select, active low
SCLK      in   1   SPI clock; idles high; MOSI sampled on rise
MOSI      in   1   master-out data
MISO      out  1   serf-out data
INT       out  1   data-ready interrupt, active high
smpl_vld  in   1   one-clk strobe: new sample present on the inputs below
roll_rt   in   16  roll rate sample
yaw_rt    in   16  yaw rate sample
AY        in   16  Y acceleration sample
AZ        in   16  Z acceleration sample

Behaviour:
- Reset values: MISO=0, INT=0; all registers 0x00 except WHO_AM_I; FSM in IDLE; bit count 0.
- Synchronization:
  - SCLK, SS_n and MOSI pass through SYNC_STG flops, plus one extra flop for edge detect.
  - Internal events lag the pins by SYNC_STG+1 clk.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on SS_n falling edge: clear bit count; shft[15:0] keeps its old value.
  - In CMD and DATA, each SCLK rising edge shifts shft <= {shft[14:0], sync MOSI} and increments the 4-bit count.
  - CMD -> DATA on the 8th rise. That rise performs a combined load: shft <= {rdata, shft[6:0], MOSI}.
    - cmd_byte = {shft[6:0], MOSI}; addr = cmd_byte[6:0].
    - rdata = register at addr, or 0x00 for an unmapped address or a write frame.
  - DATA -> IDLE on SS_n rising edge after 16 rises: frame complete.
    - Write frame (shft[15]==0): reg[shft[14:8]] <= shft[7:0], for writable addresses only.
    - Read frame of 0x2D: INT clears.
  - Any SS_n rising edge with count != 16 aborts the frame: no write, no INT clear, FSM -> IDLE.
  - An SS_n falling edge in CMD or DATA restarts the frame.
- MISO = shft[15] continuously. It therefore changes SYNC_STG+1 clk after an SCLK rise, well before the next master sample.
- Register map:
  - 0x0D INT_CTRL (RW): bit1 enables INT.
  - 0x0F WHO_AM_I (RO).
  - 0x10 CTRL1_XL, 0x11 CTRL2_G, 0x14 CTRL5 (RW, storage only).
  - 0x24/0x25 roll L/H; 0x26/0x27 yaw L/H; 0x2A/0x2B AY L/H; 0x2C/0x2D AZ L/H (RO).
  - Writes to RO or unmapped addresses are ignored.
- Sample capture:
  - smpl_vld sets a pend flag.
  - pend transfers to the data registers only while the FSM is IDLE: the transfer happens on that cycle, or on the SS_n rise that ends the current frame.
  - This guarantees a burst never mixes halves within a frame.
  - On transfer, INT is set if INT_CTRL[1]=1; pend clears.
  - Simultaneous transfer and 0x2D-read clear: set wins, INT=1.
  - Multiple smpl_vld before a transfer: the last sample wins.
- Writing INT_CTRL[1]=0 clears INT at frame end.

Optional Feature:
- Macro: INERT_SERF_STATUS_EN.
- When defined, address 0x1E is STATUS (RO):
  - bit0 = INT.
  - bit1 = overrun: a transfer occurred while INT was already 1.
  - Completing a read of 0x1E clears overrun.
- When undefined, 0x1E is unmapped and reads 0x00; no overrun logic exists.

Test Plan:
- Reset, then read frame 0x8F00 -> master resp[7:0]=0x6A; INT=0.
- Write frames 0x0D02, 0x1053, 0x1150, 0x1460, then read 0x9000 -> resp[7:0]=0x53; INT_CTRL=0x02.
- smpl_vld with roll_rt=16'h1234, AZ=16'hFEDC -> INT=1. Then:
  - read 0xA400 -> 0x34; read 0xA500 -> 0x12; INT still 1.
  - read 0xAD00 -> 0xFE; INT=0 after SS_n rise.
- smpl_vld pulsed mid-frame during the 0xA400 read -> that frame returns the old value; new data and INT=1 appear after SS_n rise.
- SS_n raised after 10 SCLK rises of write 0x1011 -> CTRL2_G unchanged; the next full frame decodes correctly.
- (INERT_SERF_STATUS_EN) two smpl_vld with no reads -> read 0x9E00 returns 0x03; a second read returns 0x01.
